krv_test_monitor: RTL
=====================

// Module: krv_test_monitor
// PURPOSE
//  Synthesizable test-completion monitor for krv_e regression and FPGA bring-up. Watches the decode-stage PC,
//  detects end of test (programmable end addresses or a PC self-loop), checks a result register against a
//  pass value, enforces a cycle-count watchdog and logs UART TX bytes into a FWFT FIFO for readback.
//  Sits beside u_core/u_uart in krv_e; replaces the fixed PC/timeout checks of the simulation bench.
// PARAMETERS
//  PC_WIDTH    32  width of dec_pc and end addresses
//  DATA_WIDTH  32  width of result_reg / pass_value
//  N_END       2   number of end-address comparators
//  TIMEOUT_W   24  width of cycle counter / timeout_limit
//  STALL_CYC   16  consecutive valid cycles at the same PC that count as end of test (>=2)
//  FIFO_DEPTH  16  UART log entries, power of 2, >=2
// PORTS
//  cpu_clk       in   1                 core clock
//  porn          in   1                 asynchronous active-low reset
//  start         in   1                 pulse: arm monitor, clear results, flush log
//  dec_pc        in   PC_WIDTH          decode-stage PC
//  dec_pc_valid  in   1                 dec_pc holds a real instruction this cycle
//  end_pc        in   N_END*PC_WIDTH    end addresses, entry i at [i*PC_WIDTH +: PC_WIDTH]
//  end_pc_en     in   N_END             per-comparator enable
//  timeout_limit in   TIMEOUT_W         watchdog limit in cycles; 0 disables watchdog
//  result_reg    in   DATA_WIDTH        result register (x3/gp)
//  pass_value    in   DATA_WIDTH        value of result_reg meaning pass
//  uart_tx_wr    in   1                 UART TX data register write strobe
//  uart_tx_data  in   8                 UART TX byte
//  log_rd        in   1                 pop log head
//  log_data      out  8                 log head (FWFT), 8'h00 when empty
//  log_empty     out  1 / log_full out 1 / log_overflow out 1 (sticky: byte dropped)
//  state         out  2                 FSM state
//  test_done     out  1 / test_pass out 1 / test_fail out 1 / test_timeout out 1 / test_stall out 1
//  end_hit       out  N_END             one-hot comparator that ended the test, 0 for stall/timeout
//  cycle_count   out  TIMEOUT_W         cycles spent in RUN, saturating at all-ones
// BEHAVIOUR
//  Reset: all outputs 0 except log_empty=1; state=IDLE; FIFO pointers 0; prev-PC and stall counter 0.
//  FSM IDLE(0)->RUN(1)->CHECK(2)->DONE(3). start in IDLE or DONE -> RUN next cycle; start ignored in RUN/CHECK.
//  Entering RUN: cycle_count, end_hit, all test_* flags, stall counter, log_overflow cleared; FIFO flushed.
//  RUN: cycle_count += 1 per cycle (saturating). Priority each cycle: end match > stall > timeout.
//   end match: dec_pc_valid & end_pc_en[i] & dec_pc==end_pc[i] -> CHECK; end_hit latches all matching bits.
//   stall: on valid cycle, counter++ if dec_pc==previous valid PC else counter=1; counter reaching STALL_CYC
//     -> CHECK with test_stall=1. Invalid cycles neither advance nor reset the counter.
//   timeout: timeout_limit!=0 and cycle_count (pre-increment) == timeout_limit-1 -> DONE, test_timeout=1.
//  CHECK: exactly one cycle; samples result_reg (one cycle after the end PC, so retiring writes land);
//   equal to pass_value -> test_pass=1 else test_fail=1; -> DONE.
//  DONE: test_done=1; all result flags, end_hit, cycle_count hold until next start. pass/fail/timeout mutually exclusive.
//  Log FIFO active in every state: uart_tx_wr writes when not full, or when full with log_rd same cycle;
//   write while full without read drops byte and sets log_overflow. log_rd on empty ignored.
//   Simultaneous rd+wr when empty: write only (pop ignored). Pointers wrap modulo FIFO_DEPTH with extra wrap bit.
//   start flushes only on the cycle of entering RUN; a uart_tx_wr that same cycle is discarded.
//  porn asserted mid-test: immediate return to reset values, log contents lost.
// TESTING
//  end_pc[0]=0x48 en=01, start, PC walks to 0x48, result_reg=1, pass_value=1 -> CHECK then DONE, test_pass=1, end_hit=01.
//  Same but result_reg=0 -> test_fail=1, test_pass=0; next start clears flags, cycle_count restarts at 0.
//  end_pc_en=0, PC loops at 0x100 for STALL_CYC valid cycles (bubbles interleaved) -> test_stall=1, end_hit=0.
//  timeout_limit=100, PC never matches -> test_timeout=1 after 100 RUN cycles, cycle_count=100; limit 0 never times out.
//  End match and timeout in same cycle -> CHECK path taken, test_timeout=0.
//  Write FIFO_DEPTH+1 bytes 0x41.. no reads -> log_full=1, log_overflow=1, reads return 0x41..0x50 then log_empty=1.

Source files
------------

// File: rtl/krv_test_monitor.sv
// krv_test_monitor: end-of-test monitor for krv_e regression and FPGA bring-up.
// Watches the decode-stage PC. A test ends on one of three conditions:
// - the PC hits one of the programmable end addresses,
// - the PC sits at the same address for STALL_CYC valid cycles (a self-loop),
// - the cycle watchdog expires.
// On an end address or a self-loop, result_reg is compared with pass_value one cycle later.
// UART TX bytes are logged into a first-word-fall-through FIFO for readback.
// Ports:
//   cpu_clk, porn              clock, asynchronous active-low reset
//   start                      arm the monitor, clear results, flush the log
//   dec_pc, dec_pc_valid       decode-stage PC and its qualifier
//   end_pc, end_pc_en          end-address comparators (entry i at [i*PC_WIDTH +: PC_WIDTH])
//   timeout_limit              watchdog limit in cycles, 0 disables it
//   result_reg, pass_value     result check operands
//   uart_tx_wr, uart_tx_data   UART TX byte capture
//   log_rd, log_data, log_*    log FIFO pop, head byte and status
//   state, test_*, end_hit     FSM state and test outcome
//   cycle_count                cycles spent in RUN, saturating
module krv_test_monitor #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_END      = 2,
  parameter int unsigned TIMEOUT_W  = 24,
  parameter int unsigned STALL_CYC  = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                      cpu_clk,
  input  logic                      porn,
  input  logic                      start,
  input  logic [PC_WIDTH-1:0]       dec_pc,
  input  logic                      dec_pc_valid,
  input  logic [N_END*PC_WIDTH-1:0] end_pc,
  input  logic [N_END-1:0]          end_pc_en,
  input  logic [TIMEOUT_W-1:0]      timeout_limit,
  input  logic [DATA_WIDTH-1:0]     result_reg,
  input  logic [DATA_WIDTH-1:0]     pass_value,
  input  logic                      uart_tx_wr,
  input  logic [7:0]                uart_tx_data,
  input  logic                      log_rd,
  output logic [7:0]                log_data,
  output logic                      log_empty,
  output logic                      log_full,
  output logic                      log_overflow,
  output logic [1:0]                state,
  output logic                      test_done,
  output logic                      test_pass,
  output logic                      test_fail,
  output logic                      test_timeout,
  output logic                      test_stall,
  output logic [N_END-1:0]          end_hit,
  output logic [TIMEOUT_W-1:0]      cycle_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrPW  = PtrW + 1;
  localparam int unsigned StallW = $clog2(STALL_CYC + 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StCheck = 2'd2, StDone = 2'd3} state_e;

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   count_q, count_d;
  logic [N_END-1:0]       hit_q, hit_d;
  logic                   pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, stall_q, stall_d;
  logic [StallW-1:0]      stall_cnt_q, stall_cnt_d, stall_next;
  logic [PC_WIDTH-1:0]    prev_pc_q, prev_pc_d;
  logic [N_END-1:0]       match_vec;
  logic                   stall_hit, timeout_hit, arm;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [PtrW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   ovf_q, ovf_d, fifo_we, fifo_empty, fifo_full;

  always_comb begin
    for (int unsigned i = 0; i < N_END; i++) begin
      match_vec[i] = dec_pc_valid & end_pc_en[i] & (dec_pc == end_pc[i*PC_WIDTH +: PC_WIDTH]);
    end
  end

  // Run length of identical valid PCs; bubbles leave it untouched.
  assign stall_next  = (dec_pc == prev_pc_q) ? stall_cnt_q + StallW'(1) : StallW'(1);
  assign stall_hit   = dec_pc_valid && (stall_next == StallW'(STALL_CYC));
  assign timeout_hit = (timeout_limit != '0) && (count_q == timeout_limit - TIMEOUT_W'(1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hit_d       = hit_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    stall_d     = stall_q;
    stall_cnt_d = stall_cnt_q;
    prev_pc_d   = prev_pc_q;
    arm         = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          count_d     = '0;
          hit_d       = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          tmo_d       = 1'b0;
          stall_d     = 1'b0;
          stall_cnt_d = '0;
          arm         = 1'b1;
        end
      end
      StRun: begin
        if (count_q != '1) count_d = count_q + TIMEOUT_W'(1);
        if (dec_pc_valid) begin
          prev_pc_d   = dec_pc;
          stall_cnt_d = stall_next;
        end
        if (match_vec != '0) begin
          state_d = StCheck;
          hit_d   = match_vec;
        end else if (stall_hit) begin
          state_d = StCheck;
          stall_d = 1'b1;
        end else if (timeout_hit) begin
          state_d = StDone;
          tmo_d   = 1'b1;
        end
      end
      StCheck: begin
        // Sampled one cycle after the end PC so the retiring write has landed.
        if (result_reg == pass_value) pass_d = 1'b1;
        else                          fail_d = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) begin
      state_q     <= StIdle;
      count_q     <= '0;
      hit_q       <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      prev_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      prev_pc_q   <= prev_pc_d;
    end
  end

  // Log FIFO: pointers carry an extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    fifo_we  = 1'b0;
    if (arm) begin
      // Flush on arming; a byte written this same cycle is discarded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (log_rd && !fifo_empty) rd_ptr_d = rd_ptr_q + PtrPW'(1);
      if (uart_tx_wr) begin
        // When full, a same-cycle pop frees the slot being written.
        if (!fifo_full || log_rd) begin
          fifo_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrPW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (fifo_we) mem[wr_ptr_q[PtrW-1:0]] <= uart_tx_data;
  end

  assign log_data     = fifo_empty ? 8'h00 : mem[rd_ptr_q[PtrW-1:0]];
  assign log_empty    = fifo_empty;
  assign log_full     = fifo_full;
  assign log_overflow = ovf_q;
  assign state        = state_q;
  assign test_done    = (state_q == StDone);
  assign test_pass    = pass_q;
  assign test_fail    = fail_q;
  assign test_timeout = tmo_q;
  assign test_stall   = stall_q;
  assign end_hit      = hit_q;
  assign cycle_count  = count_q;

endmodule
